stream_demux_1_2: RTL and testbench

- Sequential 1-to-2 demultiplexer: the receive-side counterpart of our 2:1 mux.
- One valid/ready input stream carries a data word plus a select bit. Each word is steered into one of two per-channel FIFOs, and each FIFO drains on its own valid/ready output.
- Sits after any shared 2:1-muxed link to split the traffic back into two independent consumers.
- Also supports an alternating (round-robin) mode and per-channel accept counters for debug.

---
 rtl/demux_pkg.sv | 23 ++
 rtl/stream_demux_1_2_if.sv | 33 +++
 rtl/demux_fifo.sv | 74 +++++++
 rtl/stream_demux_1_2.sv | 110 +++++++++++
 tb/tb_stream_demux_1_2.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int DEF_W     = 32'sd8;
  localparam int DEF_DEPTH = 32'sd4;
  localparam int DEF_CNT_W = 32'sd8;

  function automatic int clog2(input int n);
    int r;
    int p;
    r = 32'sd0;
    p = 32'sd1;
    while (p < n) begin
      p = p * 32'sd2;
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_demux_1_2_if.sv
// Bundles the input stream, both output streams and the debug counters of the demux.
interface stream_demux_1_2_if
  import demux_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             alt_mode;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [W-1:0]     out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [W-1:0]     out1_data;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output alt_mode, in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

  modport slave (
    input  alt_mode, in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

endinterface

// File: rtl/demux_fifo.sv
// First-word fall-through FIFO; the head entry is visible while the FIFO is non-empty.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int OCC_W = PTR_W + 32'sd1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  // Flag decode and qualification of push/pop against the flags.
  always_comb begin
    full_s  = (occ_r == OCC_W'(DEPTH));
    empty_s = (occ_r == OCC_W'(0));
    push_s  = push && !full_s;
    pop_s   = pop && !empty_s;
  end

  // Storage: cleared on reset, written only on a qualified push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign full  = full_s;
  assign empty = empty_s;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/stream_demux_1_2.sv
// Steers one valid/ready stream into two per-channel FWFT FIFOs, by select bit or round-robin.
module stream_demux_1_2
  import demux_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  stream_demux_1_2_if.slave bus
);

  logic             dest_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             push0_s;
  logic             push1_s;
  logic             full0_s;
  logic             full1_s;
  logic             empty0_s;
  logic             empty1_s;
  logic [W-1:0]     head0_s;
  logic [W-1:0]     head1_s;
  logic             toggle_r;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  // in_ready looks only at the destination FIFO, never at the output handshakes.
  always_comb begin
    dest_s     = CH0;
    in_ready_s = 1'b0;
    if (bus.alt_mode) begin
      dest_s = toggle_r;
    end else begin
      dest_s = bus.in_sel;
    end
    case (dest_s)
      CH0:     in_ready_s = !full0_s;
      CH1:     in_ready_s = !full1_s;
      default: in_ready_s = 1'b0;
    endcase
    accept_s = bus.in_valid && in_ready_s;
    push0_s  = accept_s && (dest_s == CH0);
    push1_s  = accept_s && (dest_s == CH1);
  end

  demux_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0_s),
    .push_data (bus.in_data),
    .pop       (bus.out0_ready),
    .full      (full0_s),
    .empty     (empty0_s),
    .head      (head0_s)
  );

  demux_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1_s),
    .push_data (bus.in_data),
    .pop       (bus.out1_ready),
    .full      (full1_s),
    .empty     (empty1_s),
    .head      (head1_s)
  );

  // Round-robin toggle advances only on an accept made in alternating mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_r <= 1'b0;
    end else if (accept_s && bus.alt_mode) begin
      toggle_r <= ~toggle_r;
    end else begin
      toggle_r <= toggle_r;
    end
  end

  // Saturating per-channel accept counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else begin
      if (push0_s && (cnt0_r != {CNT_W{1'b1}})) begin
        cnt0_r <= cnt0_r + CNT_W'(1);
      end
      if (push1_s && (cnt1_r != {CNT_W{1'b1}})) begin
        cnt1_r <= cnt1_r + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out0_valid = !empty0_s;
  assign bus.out0_data  = head0_s;
  assign bus.out1_valid = !empty1_s;
  assign bus.out1_data  = head1_s;
  assign bus.cnt0       = cnt0_r;
  assign bus.cnt1       = cnt1_r;

endmodule

// File: tb/tb_stream_demux_1_2.sv
// Scoreboard bench for stream_demux_1_2: directed vectors push expected words, a monitor checks pops.
module tb_stream_demux_1_2;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_demux_1_2_if #(.W(8), .CNT_W(8)) a ();
  stream_demux_1_2_if #(.W(8), .CNT_W(2)) b ();

  stream_demux_1_2 #(.W(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  stream_demux_1_2 #(.W(8), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops the channel's expected queue.
  always @(negedge clk) begin
    if (rst_n && a.out0_valid && a.out0_ready) begin
      if (exp0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ch0_unexpected: got %0h expected no word", a.out0_data);
      end else begin
        check("ch0_data", {24'h0, a.out0_data}, {24'h0, exp0.pop_front()});
      end
    end
    if (rst_n && a.out1_valid && a.out1_ready) begin
      if (exp1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ch1_unexpected: got %0h expected no word", a.out1_data);
      end else begin
        check("ch1_data", {24'h0, a.out1_data}, {24'h0, exp1.pop_front()});
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic sel, input logic ch);
    bit done;
    done = 1'b0;
    a.in_valid = 1'b1;
    a.in_data  = d;
    a.in_sel   = sel;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (a.in_ready) begin
        if (ch == CH0) exp0.push_back(d);
        else           exp1.push_back(d);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for word %0h", d);
    end
    @(posedge clk); #1;
    a.in_valid = 1'b0;
    a.in_data  = 8'h00;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    a.out0_ready = 1'b1;
    a.out1_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!a.out0_valid && !a.out1_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got valid still high expected empty");
    end
    @(posedge clk); #1;
    a.out0_ready = 1'b0;
    a.out1_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a.alt_mode = 1'b0; a.in_valid = 1'b0; a.in_data = 8'h00; a.in_sel = 1'b0;
    a.out0_ready = 1'b0; a.out1_ready = 1'b0;
    b.alt_mode = 1'b0; b.in_valid = 1'b0; b.in_data = 8'h00; b.in_sel = 1'b0;
    b.out0_ready = 1'b0; b.out1_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_in_ready", {31'h0, a.in_ready}, 32'h1);
    check("rst_out0_valid", {31'h0, a.out0_valid}, 32'h0);
    check("rst_out1_valid", {31'h0, a.out1_valid}, 32'h0);
    check("rst_cnt0", {24'h0, a.cnt0}, 32'h0);
    check("rst_cnt1", {24'h0, a.cnt1}, 32'h0);
    check("rst_out0_data", {24'h0, a.out0_data}, 32'h0);
    check("rst_out1_data", {24'h0, a.out1_data}, 32'h0);

    // Steering by in_sel
    send(8'hA1, 1'b0, CH0);
    check("steer_out0_valid", {31'h0, a.out0_valid}, 32'h1);
    check("steer_out0_data", {24'h0, a.out0_data}, 32'hA1);
    check("steer_out1_idle", {31'h0, a.out1_valid}, 32'h0);
    send(8'hB2, 1'b1, CH1);
    check("steer_out1_valid", {31'h0, a.out1_valid}, 32'h1);
    check("steer_out1_data", {24'h0, a.out1_data}, 32'hB2);
    check("steer_cnt0", {24'h0, a.cnt0}, 32'h1);
    check("steer_cnt1", {24'h0, a.cnt1}, 32'h1);
    drain();

    // Full channel 0 with backpressure; channel 1 keeps draining
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b0, CH0);
    send(8'h20, 1'b1, CH1);
    a.out1_ready = 1'b1;
    fork
      send(8'h14, 1'b0, CH0);
      begin
        repeat (3) @(negedge clk);
        check("stall_in_ready", {31'h0, a.in_ready}, 32'h0);
        check("stall_ch1_flowed", {31'h0, a.out1_valid}, 32'h0);
        check("stall_ch0_head", {24'h0, a.out0_data}, 32'h10);
        @(posedge clk); #1 a.out0_ready = 1'b1;
        @(posedge clk); #1 a.out0_ready = 1'b0;
      end
    join
    check("full_head_after_pop", {24'h0, a.out0_data}, 32'h11);
    check("full_cnt0", {24'h0, a.cnt0}, 32'h6);
    a.out1_ready = 1'b0;
    drain();

    // Asynchronous reset between edges with three words buffered
    send(8'h30, 1'b0, CH0);
    send(8'h31, 1'b0, CH0);
    send(8'h32, 1'b1, CH1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_out0_valid", {31'h0, a.out0_valid}, 32'h0);
    check("arst_out1_valid", {31'h0, a.out1_valid}, 32'h0);
    check("arst_out0_data", {24'h0, a.out0_data}, 32'h0);
    check("arst_out1_data", {24'h0, a.out1_data}, 32'h0);
    check("arst_cnt0", {24'h0, a.cnt0}, 32'h0);
    check("arst_in_ready", {31'h0, a.in_ready}, 32'h1);
    exp0.delete();
    exp1.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Alternating mode ignores in_sel
    a.alt_mode = 1'b1;
    send(8'h01, 1'b1, CH0);
    send(8'h02, 1'b1, CH1);
    send(8'h03, 1'b1, CH0);
    send(8'h04, 1'b1, CH1);
    check("alt_cnt0", {24'h0, a.cnt0}, 32'h2);
    check("alt_cnt1", {24'h0, a.cnt1}, 32'h2);
    check("alt_out0_head", {24'h0, a.out0_data}, 32'h01);
    check("alt_out1_head", {24'h0, a.out1_data}, 32'h02);
    drain();
    a.alt_mode = 1'b0;

    // Channel 1 held at two entries with push and pop every cycle across pointer wrap
    send(8'h40, 1'b1, CH1);
    send(8'h41, 1'b1, CH1);
    for (int i = 0; i < 10; i++) begin
      a.in_valid   = 1'b1;
      a.in_data    = 8'(8'h42 + i);
      a.in_sel     = 1'b1;
      a.out1_ready = 1'b1;
      @(negedge clk);
      check("wrap_in_ready", {31'h0, a.in_ready}, 32'h1);
      check("wrap_out1_valid", {31'h0, a.out1_valid}, 32'h1);
      if (a.in_ready) exp1.push_back(a.in_data);
      @(posedge clk); #1;
    end
    a.in_valid   = 1'b0;
    a.out1_ready = 1'b0;
    @(negedge clk);
    check("wrap_head", {24'h0, a.out1_data}, 32'h4A);
    @(posedge clk); #1 a.out1_ready = 1'b1;
    @(posedge clk); #1;
    check("wrap_second", {24'h0, a.out1_data}, 32'h4B);
    check("wrap_second_valid", {31'h0, a.out1_valid}, 32'h1);
    @(posedge clk); #1 a.out1_ready = 1'b0;
    check("wrap_empty", {31'h0, a.out1_valid}, 32'h0);

    // Counter saturation on the 2-bit instance
    b.out0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b.in_valid = 1'b1;
      b.in_data  = 8'(i);
      @(posedge clk); #1;
      if (i == 1) check("sat_cnt0_two", {30'h0, b.cnt0}, 32'h2);
    end
    b.in_valid = 1'b0;
    check("sat_cnt0", {30'h0, b.cnt0}, 32'h3);
    check("sat_cnt1", {30'h0, b.cnt1}, 32'h0);
    b.out0_ready = 1'b0;

    @(negedge clk);
    check("ch0_leftover", exp0.size(), 32'h0);
    check("ch1_leftover", exp1.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
